// File: rtl/min_pkg.sv
// Shared definitions for the MIN instruction prefetch path.
package min_pkg;

    localparam int MIN_WORD_W = 16;
    localparam int MIN_ADDR_W = 16;

    localparam logic [MIN_ADDR_W-1:0] MIN_RESET_PC = 16'h0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STALL,
        ST_DISCARD
    } fetch_state_t;

    // One buffered instruction: the word and the address it came from.
    typedef struct packed {
        logic [MIN_ADDR_W-1:0] pc;
        logic [MIN_WORD_W-1:0] word;
    } ins_entry_t;

endpackage

// File: rtl/min_ins_fifo.sv
// Instruction queue: synchronous FIFO of {pc, word} with a registered head.
// Flush wins over push and pop. A push into a full queue is refused unless a
// pop frees a slot in the same cycle.
module min_ins_fifo
    import min_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  ins_entry_t       push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output ins_entry_t       head
);

    ins_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] count_n;
    logic             valid_q;
    logic             pop_eff;
    logic             push_eff;
    ins_entry_t       head_q;
    ins_entry_t       head_n;

    // Next-state of pointers, count and the head word that will be presented.
    always_comb begin
        pop_eff  = pop && valid_q;
        push_eff = push && ((count_q != CNT_W'(DEPTH)) || pop_eff);
        rd_ptr_n = rd_ptr + PTR_W'(pop_eff);
        remain   = count_q - CNT_W'(pop_eff);
        count_n  = remain + CNT_W'(push_eff);
        // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
        head_n   = mem[rd_ptr_n];
        if (count_n == '0) begin
            head_n = '0;
        end else if (remain == '0) begin
            head_n = push_data;
        end
    end

    // Entry storage write.
    // NOTE: the storage array is deliberately not reset; only pointers/count are, which is enough to make it empty.
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, count and registered head update; flush behaves like reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push_eff);
            rd_ptr  <= rd_ptr_n;
            count_q <= count_n;
            valid_q <= (count_n != '0);
            head_q  <= head_n;
        end
    end

    assign count = count_q;
    assign valid = valid_q;
    assign head  = head_q;

endmodule

// File: rtl/min_fetch_unit.sv
// Instruction prefetch unit: requests sequential words from instruction
// memory, queues them for the execution unit and restarts on redirects.
module min_fetch_unit
    import min_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [MIN_ADDR_W-1:0] RESET_PC = MIN_RESET_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [MIN_ADDR_W-1:0]   mem_addr,
    input  logic                    mem_ack,
    input  logic [MIN_WORD_W-1:0]   mem_rdata,
    output logic                    ins_valid,
    output logic [MIN_WORD_W-1:0]   ins_data,
    output logic [MIN_ADDR_W-1:0]   ins_pc,
    input  logic                    ins_ready,
    input  logic                    redirect,
    input  logic [MIN_ADDR_W-1:0]   redirect_pc,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t          state;
    // Next sequential fetch address; while in DISCARD it holds the redirect target.
    logic [MIN_ADDR_W-1:0] fetch_pc;
    logic [MIN_ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      occ_after;
    logic                  fifo_valid;
    logic                  push;
    logic                  pop;
    ins_entry_t            push_entry;
    ins_entry_t            head;

    // A word is kept only when acked in FETCH and not killed by a redirect.
    assign push       = (state == ST_FETCH) && mem_ack && !redirect;
    assign pop        = fifo_valid && ins_ready;
    assign push_entry = '{pc: mem_addr, word: mem_rdata};
    assign pc_inc     = fetch_pc + MIN_ADDR_W'(1);

    // Queue occupancy as it will be after this edge; drives stall decisions.
    always_comb begin
        occ_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
        if (redirect) begin
            occ_after = '0;
        end
    end

    // Fetch sequencer with registered request outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_FETCH;
                    mem_req <= 1'b1;
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        mem_addr <= redirect_pc;
                    end else begin
                        mem_addr <= fetch_pc;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            mem_addr <= redirect_pc;
                        end else begin
                            // Request is in flight; keep it stable and drop its data later.
                            state <= ST_DISCARD;
                        end
                    end else if (mem_ack) begin
                        fetch_pc <= pc_inc;
                        mem_addr <= pc_inc;
                        if (occ_after == CNT_W'(DEPTH)) begin
                            state   <= ST_STALL;
                            mem_req <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        mem_addr <= redirect_pc;
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                    end else if (occ_after < CNT_W'(DEPTH)) begin
                        state   <= ST_FETCH;
                        mem_req <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state    <= ST_FETCH;
                        mem_addr <= redirect ? redirect_pc : fetch_pc;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    min_ins_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (ins_ready),
        .flush     (redirect),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .head      (head)
    );

    assign ins_valid = fifo_valid;
    assign ins_data  = head.word;
    assign ins_pc    = head.pc;
    assign occupancy = fifo_count;

endmodule

// File: tb/tb_min_fetch_unit.sv
// Directed bench for min_fetch_unit: a cycle table for the streaming,
// backpressure, redirect and wrap cases, then hand sequences for a redirect
// during a slow ack and a reset during DISCARD.
module tb_min_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    bit manual_mem = 1'b0;

    always #5 clk = ~clk;

    min_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .occupancy   (occupancy)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic        chk_head;
        logic [15:0] e_pc;
        logic [15:0] e_data;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rdy, logic redir, logic [15:0] rpc,
                                logic req, logic [15:0] addr, logic v, logic ch,
                                logic [15:0] pc, logic [15:0] data, logic [2:0] occ);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.e_req = req; r.e_addr = addr; r.e_valid = v; r.chk_head = ch;
        r.e_pc = pc; r.e_data = data; r.e_occ = occ;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are then stable and the zero-wait memory answers.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!manual_mem) begin
            mem_ack   = mem_req;
            mem_rdata = mem_addr ^ 16'hA500;
        end
    endtask

    task automatic check_req(input string tag, input logic req, input logic [15:0] addr,
                             input logic v, input logic [2:0] occ);
        check({tag, ".mem_req"},   32'(mem_req),   32'(req));
        check({tag, ".mem_addr"},  32'(mem_addr),  32'(addr));
        check({tag, ".ins_valid"}, 32'(ins_valid), 32'(v));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin
        reset = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Phase A: boot with backpressure, single-cycle ready pulse, redirect from STALL.
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000,0,1,16'h0000,16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,16'h0000,0,1,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,0,0,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0001,1,1,16'h0000,16'hA500,1));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0002,1,1,16'h0000,16'hA500,2));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0003,1,1,16'h0000,16'hA500,3));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0004,1,1,16'h0000,16'hA500,4));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0004,1,1,16'h0000,16'hA500,4));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0004,1,1,16'h0001,16'hA501,3));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0005,1,1,16'h0001,16'hA501,4));
        vecs.push_back(mk(1,0,0,16'h0000, 0,16'h0005,1,1,16'h0001,16'hA501,4));
        vecs.push_back(mk(1,0,1,16'h0200, 1,16'h0200,0,0,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0201,1,1,16'h0200,16'hA700,1));
        // Phase B: reset, full-rate stream, redirect with 3 queued words, wrap-around.
        vecs.push_back(mk(0,1,0,16'h0000, 0,16'h0000,0,1,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0000,0,0,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0001,1,1,16'h0000,16'hA500,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0002,1,1,16'h0001,16'hA501,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0003,1,1,16'h0002,16'hA502,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0004,1,1,16'h0003,16'hA503,1));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0005,1,1,16'h0003,16'hA503,2));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0006,1,1,16'h0003,16'hA503,3));
        vecs.push_back(mk(1,1,1,16'h0040, 1,16'h0040,0,0,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0041,1,1,16'h0040,16'hA540,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0042,1,1,16'h0041,16'hA541,1));
        vecs.push_back(mk(1,1,1,16'hFFFE, 1,16'hFFFE,0,0,16'h0000,16'h0000,0));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'hFFFF,1,1,16'hFFFE,16'h5AFE,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0000,1,1,16'hFFFF,16'h5AFF,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0001,1,1,16'h0000,16'hA500,1));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0002,1,1,16'h0001,16'hA501,1));

        foreach (vecs[i]) begin
            string tag;
            tag         = $sformatf("v%0d", i);
            reset       = vecs[i].rst;
            ins_ready   = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            check_req(tag, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_occ);
            if (vecs[i].chk_head) begin
                check({tag, ".ins_pc"},   32'(ins_pc),   32'(vecs[i].e_pc));
                check({tag, ".ins_data"}, 32'(ins_data), 32'(vecs[i].e_data));
            end
        end
        redirect = 1'b0;

        // Redirect while an ack is outstanding at address 5.
        manual_mem = 1'b1;
        ins_ready  = 1'b1;
        reset = 1'b0; mem_ack = 1'b0; tick();
        check_req("mw.reset", 1'b0, 16'h0000, 1'b0, 3'd0);
        reset = 1'b1; tick();
        check_req("mw.boot", 1'b1, 16'h0000, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            mem_ack = 1'b1; mem_rdata = mem_addr ^ 16'hA500; tick();
        end
        check_req("mw.at5", 1'b1, 16'h0005, 1'b1, 3'd1);
        check("mw.at5.ins_pc", 32'(ins_pc), 32'h0004);
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100; tick();
        redirect = 1'b0;
        check_req("mw.redir", 1'b1, 16'h0005, 1'b0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            mem_ack = 1'b0; tick();
            check_req($sformatf("mw.wait%0d", k), 1'b1, 16'h0005, 1'b0, 3'd0);
        end
        mem_ack = 1'b1; mem_rdata = 16'h0005 ^ 16'hA500; tick();
        check_req("mw.drop", 1'b1, 16'h0100, 1'b0, 3'd0);
        mem_ack = 1'b1; mem_rdata = 16'hA400; tick();
        check_req("mw.resume", 1'b1, 16'h0101, 1'b1, 3'd1);
        check("mw.resume.ins_pc",   32'(ins_pc),   32'h0100);
        check("mw.resume.ins_data", 32'(ins_data), 32'hA400);

        // Second redirect during DISCARD, then reset while in DISCARD.
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300; tick();
        check_req("rd.disc", 1'b1, 16'h0101, 1'b0, 3'd0);
        redirect_pc = 16'h0380; mem_ack = 1'b1; mem_rdata = 16'hBEEF; tick();
        redirect = 1'b0;
        check_req("rd.second", 1'b1, 16'h0380, 1'b0, 3'd0);
        mem_ack = 1'b0; tick();
        check_req("rd.wait", 1'b1, 16'h0380, 1'b0, 3'd0);
        redirect = 1'b1; redirect_pc = 16'h0500; tick();
        redirect = 1'b0;
        check_req("rd.disc2", 1'b1, 16'h0380, 1'b0, 3'd0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD; tick();
        check_req("rd.reset", 1'b0, 16'h0000, 1'b0, 3'd0);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; tick();
        check_req("rd.late_ack", 1'b1, 16'h0000, 1'b0, 3'd0);
        mem_ack = 1'b1; mem_rdata = 16'hA500; tick();
        check_req("rd.restart", 1'b1, 16'h0001, 1'b1, 3'd1);
        check("rd.restart.ins_pc",   32'(ins_pc),   32'h0000);
        check("rd.restart.ins_data", 32'(ins_data), 32'hA500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/min_fetch_unit.md
# min_fetch_unit

Instruction prefetch unit for the MIN execution unit. It issues 16-bit word reads to instruction memory over a req/ack port and buffers returned words in a small FIFO. It presents them to the execution unit's instruction register (IRF/IRE) stage over a valid/ready handshake. It also accepts branch/jump redirects from the execution unit, flushing buffered words and restarting the fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4, instruction queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- mem_req  out  1  read request, held until acknowledged
- mem_addr  out  16  word address of current request; stable while mem_req=1
- mem_ack  in  1  memory accepts request; mem_rdata valid in the same cycle
- mem_rdata  in  16  instruction word returned
- ins_valid  out  1  queue head valid
- ins_data  out  16  queue head instruction word
- ins_pc  out  16  address the head word was fetched from
- ins_ready  in  1  execution unit consumes head this cycle
- redirect  in  1  one-cycle pulse: flush queue, refetch from redirect_pc
- redirect_pc  in  16  new fetch address, sampled when redirect=1
- occupancy  out  log2(DEPTH)+1  current queue count (debug/visibility)

## Operation
- Reset (reset=0 at an edge): state IDLE, fetch_pc=RESET_PC, queue empty. Outputs: mem_req=0, mem_addr=RESET_PC, ins_valid=0, ins_data=0, ins_pc=0, occupancy=0.
- FSM states: IDLE, FETCH, STALL, DISCARD.
  - IDLE → FETCH at the first edge with reset=1.
  - FETCH: mem_req=1, mem_addr=fetch_pc. On mem_ack, the word and fetch_pc are pushed, and fetch_pc increments by 1, wrapping from 16'hFFFF to 16'h0000. If post-edge occupancy == DEPTH, go to STALL. Otherwise stay in FETCH.
  - STALL: mem_req=0. Go to FETCH when occupancy < DEPTH.
  - DISCARD: entered on redirect while mem_req=1 and mem_ack=0. mem_req and mem_addr are held unchanged until mem_ack. The returned word is dropped. Then go to FETCH at the latched redirect_pc.
- Handshake: a pop occurs when ins_valid && ins_ready. A push and a pop in the same cycle leave occupancy unchanged. ins_ready with ins_valid=0 is ignored.
- Redirect has priority over everything:
  - The queue is flushed, and a pop in the same cycle is void; the consumer discards that word.
  - fetch_pc is set to redirect_pc.
  - From FETCH with mem_ack=1 in the same cycle, the acked word is dropped and the next state is FETCH at redirect_pc.
  - From FETCH with mem_ack=0, the next state is DISCARD.
  - From STALL or IDLE, the next state is FETCH.
  - A second redirect during DISCARD overwrites the latched pc.
- The queue is never overfilled. The memory is never asked for a word that has no slot.
- Reset mid-operation (including in DISCARD) aborts immediately. mem_req drops at that edge, and an outstanding ack is ignored.

## Timing
- All outputs are registered.
- Reset release to first request: mem_req=1 in the cycle after the first edge with reset=1.
- Fetch latency: ack sampled at edge E gives ins_valid=1 in the cycle after E.
- Throughput: one word per cycle with mem_ack held high and ins_ready=1.
- Redirect sampled at edge R gives ins_valid=0 in the cycle after R.
  - Zero-wait memory: first new word valid 2 cycles after R.
  - If the redirect entered DISCARD, delay by the remaining ack wait plus 1.

## Structure
- Shared package min_pkg holds:
  - fetch FSM state enum
  - MIN_WORD_W=16
  - MIN_ADDR_W=16
  - default RESET_PC
- Sub-module min_ins_fifo:
  - synchronous FIFO of {pc, word}, parameter DEPTH
  - ports: push, pop, flush, count, head
  - flush has priority over push and pop
- The top level holds the FSM, fetch_pc, and the redirect latch.

## Test plan
- Reset/boot: reset low 2 cycles, then high, zero-wait memory returning addr^16'hA500, ins_ready=1 → fetches 0,1,2,… and ins_data=16'hA500,16'hA501,… on consecutive cycles, starting 2 cycles after release.
- Backpressure: ins_ready=0 with DEPTH=4 → exactly 4 acks, then mem_req=0 and occupancy=4. Pulsing ins_ready for one cycle → exactly one new request at address 4.
- Redirect with zero-wait memory: redirect to 16'h0040 while the queue holds 3 words → next ins_valid carries ins_pc=16'h0040. No word with pc<16'h0040 from the old stream appears.
- Redirect mid-wait: mem_ack delayed 3 cycles at addr 5, redirect to 16'h0100 → mem_addr stays 5 until ack, that word is dropped, and the next mem_addr is 16'h0100.
- Wrap-around: redirect_pc=16'hFFFE → ins_pc sequence FFFE, FFFF, 0000, 0001.
- Reset during DISCARD: reset low for 1 cycle → mem_req=0 and occupancy=0, then fetch restarts at RESET_PC. A late ack is ignored.
